// File: rtl/fmap_stream_reader.sv
// Frame buffer between two conv stages: captures one feature map in raster order, then replays it.
// Build option FMAP_PAD_EN: replay a (WIDTH+2)^2 map with a 1-pixel zero border.
module fmap_stream_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CH         = 32,
  parameter int unsigned WIDTH      = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH*CH-1:0] i_data,
  input  logic                     valid_in,
  input  logic                     hold,
  output logic [DATA_WIDTH*CH-1:0] o_data,
  output logic                     valid_out,
  output logic                     frame_done,
  output logic                     overflow
);

  localparam int unsigned WW    = DATA_WIDTH * CH;
  localparam int unsigned DEPTH = WIDTH * WIDTH;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef FMAP_PAD_EN
  localparam int unsigned PW    = $clog2(WIDTH + 2);
`endif

  typedef enum logic {S_FILL, S_DRAIN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          issue_done_q, issue_done_d;
  logic          s1_vld_q, s1_vld_d;
  logic          s1_last_q, s1_last_d;
  logic          s1_zero_q, s1_zero_d;
  logic [WW-1:0] o_data_q, o_data_d;
  logic          valid_out_q, valid_out_d;
  logic          last_q, last_d;
  logic          overflow_q, overflow_d;
`ifdef FMAP_PAD_EN
  logic [PW-1:0] row_q, row_d;
  logic [PW-1:0] col_q, col_d;
`endif

  logic [WW-1:0] mem [DEPTH];
  logic [WW-1:0] ram_rd_q;

  logic adv, issue, ram_re, wr_en, consume_last;
  logic issue_zero, issue_last;

  // Classify the position about to be issued: zero border and last-of-frame.
  always_comb begin
    issue_zero = 1'b0;
    issue_last = 1'b0;
`ifdef FMAP_PAD_EN
    issue_zero = (row_q == '0) || (row_q == PW'(WIDTH + 1)) ||
                 (col_q == '0) || (col_q == PW'(WIDTH + 1));
    issue_last = (row_q == PW'(WIDTH + 1)) && (col_q == PW'(WIDTH + 1));
`else
    issue_last = (rd_addr_q == AW'(DEPTH - 1));
`endif
  end

  // Next-state: fill counter, read issue, and a two-stage read pipeline that stalls as one unit.
  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    issue_done_d = issue_done_q;
    s1_vld_d     = s1_vld_q;
    s1_last_d    = s1_last_q;
    s1_zero_d    = s1_zero_q;
    o_data_d     = o_data_q;
    valid_out_d  = valid_out_q;
    last_d       = last_q;
    overflow_d   = overflow_q;
`ifdef FMAP_PAD_EN
    row_d        = row_q;
    col_d        = col_q;
`endif
    wr_en        = 1'b0;
    adv          = !valid_out_q || !hold;
    issue        = (state_q == S_DRAIN) && !issue_done_q && adv;
    ram_re       = issue && !issue_zero;
    consume_last = valid_out_q && last_q && !hold;

    if (state_q == S_FILL) begin
      if (valid_in) begin
        wr_en = 1'b1;
        if (wr_addr_q == AW'(DEPTH - 1)) begin
          wr_addr_d = '0;
          state_d   = S_DRAIN;
        end else begin
          wr_addr_d = wr_addr_q + AW'(1);
        end
      end
    end else if (valid_in) begin
      overflow_d = 1'b1;
    end

    if (issue) begin
`ifdef FMAP_PAD_EN
      if (!issue_zero) rd_addr_d = rd_addr_q + AW'(1);
      if (col_q == PW'(WIDTH + 1)) begin
        col_d = '0;
        row_d = row_q + PW'(1);
      end else begin
        col_d = col_q + PW'(1);
      end
`else
      rd_addr_d = rd_addr_q + AW'(1);
`endif
      if (issue_last) issue_done_d = 1'b1;
    end

    if (adv) begin
      s1_vld_d    = issue;
      s1_last_d   = issue && issue_last;
      s1_zero_d   = issue_zero;
      o_data_d    = (s1_vld_q && !s1_zero_q) ? ram_rd_q : '0;
      valid_out_d = s1_vld_q;
      last_d      = s1_last_q;
    end

    if (consume_last) begin
      state_d      = S_FILL;
      rd_addr_d    = '0;
      issue_done_d = 1'b0;
`ifdef FMAP_PAD_EN
      row_d        = '0;
      col_d        = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_FILL;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      issue_done_q <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_zero_q    <= 1'b0;
      o_data_q     <= '0;
      valid_out_q  <= 1'b0;
      last_q       <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef FMAP_PAD_EN
      row_q        <= '0;
      col_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      issue_done_q <= issue_done_d;
      s1_vld_q     <= s1_vld_d;
      s1_last_q    <= s1_last_d;
      s1_zero_q    <= s1_zero_d;
      o_data_q     <= o_data_d;
      valid_out_q  <= valid_out_d;
      last_q       <= last_d;
      overflow_q   <= overflow_d;
`ifdef FMAP_PAD_EN
      row_q        <= row_d;
      col_q        <= col_d;
`endif
    end
  end

  // Frame RAM: single write port, registered read; contents are not reset.
  always_ff @(posedge clk) begin
    if (rst && wr_en) mem[wr_addr_q] <= i_data;
    if (ram_re)       ram_rd_q       <= mem[rd_addr_q];
  end

  assign o_data     = o_data_q;
  assign valid_out  = valid_out_q;
  assign overflow   = overflow_q;
  // Pulses in the same cycle the final word is taken downstream.
  assign frame_done = consume_last;

endmodule
